ex_mem_stage: RTL and testbench

Execute-to-memory pipeline stage that sits directly downstream of the ALU. It registers the ALU result together with destination and memory-control fields. It holds the architectural NZCV status register and evaluates a 4-bit condition code against it so that predicated instructions are squashed. Stall and flush come from the hazard unit; outputs feed the memory stage and the forwarding network.

---
 rtl/ex_mem_stage.sv | 108 ++++++++++
 tb/tb_ex_mem_stage.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// Execute-to-memory pipeline register with NZCV status and
// condition-code evaluation for predicated instruction squash.
module ex_mem_stage #(
  parameter int WIDTH   = 16,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               stall,
  input  logic               flush,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic               alu_n,
  input  logic               alu_z,
  input  logic               alu_v,
  input  logic               alu_c,
  input  logic               set_flags,
  input  logic [3:0]         cond,
  input  logic               reg_wr_in,
  input  logic [RADDR_W-1:0] rd_in,
  input  logic               mem_rd_in,
  input  logic               mem_wr_in,
  input  logic [WIDTH-1:0]   store_data_in,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic [RADDR_W-1:0] rd,
  output logic               reg_wr,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [WIDTH-1:0]   store_data,
  output logic [3:0]         flags,
  output logic [15:0]        retired_cnt,
  output logic [15:0]        squash_cnt
);

  logic fn, fz, fc, fv;
  logic cp;
  logic acc;

  assign fn  = flags[3];
  assign fz  = flags[2];
  assign fc  = flags[1];
  assign fv  = flags[0];
  assign acc = in_valid & ~stall & ~flush;

  // Condition pass against the flags as they stand before this instruction
  always_comb begin
    cp = 1'b0;
    unique case (cond)
      4'b0000: cp = fz;
      4'b0001: cp = ~fz;
      4'b0010: cp = fc;
      4'b0011: cp = ~fc;
      4'b0100: cp = fn;
      4'b0101: cp = ~fn;
      4'b0110: cp = fv;
      4'b0111: cp = ~fv;
      4'b1000: cp = fc & ~fz;
      4'b1001: cp = ~fc | fz;
      4'b1010: cp = (fn == fv);
      4'b1011: cp = (fn != fv);
      4'b1100: cp = ~fz & (fn == fv);
      4'b1101: cp = fz | (fn != fv);
      4'b1110: cp = 1'b1;
      4'b1111: cp = 1'b0;
    endcase
  end

  // Pipeline register, status flags and retire/squash counters
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      result      <= '0;
      rd          <= '0;
      reg_wr      <= 1'b0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      store_data  <= '0;
      flags       <= 4'b0000;
      retired_cnt <= 16'd0;
      squash_cnt  <= 16'd0;
    end else if (stall && !flush) begin
      out_valid <= out_valid;
    end else if (acc && cp) begin
      out_valid   <= 1'b1;
      result      <= alu_out;
      rd          <= rd_in;
      reg_wr      <= reg_wr_in;
      mem_rd      <= mem_rd_in;
      mem_wr      <= mem_wr_in;
      store_data  <= store_data_in;
      retired_cnt <= retired_cnt + 16'd1;
      if (set_flags)
        flags <= {alu_n, alu_z, alu_c, alu_v};
    end else begin
      out_valid  <= 1'b0;
      result     <= '0;
      rd         <= '0;
      reg_wr     <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      store_data <= '0;
      if (acc)
        squash_cnt <= squash_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus
// randomized traffic checked against a behavioural model.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, stall, flush;
  logic [15:0] alu_out;
  logic        alu_n, alu_z, alu_v, alu_c;
  logic        set_flags;
  logic [3:0]  cond;
  logic        reg_wr_in;
  logic [3:0]  rd_in;
  logic        mem_rd_in, mem_wr_in;
  logic [15:0] store_data_in;
  logic        out_valid;
  logic [15:0] result;
  logic [3:0]  rd;
  logic        reg_wr, mem_rd, mem_wr;
  logic [15:0] store_data;
  logic [3:0]  flags;
  logic [15:0] retired_cnt, squash_cnt;

  int n_vec = 0;
  int n_err = 0;

  // model state
  bit        m_valid;
  bit [15:0] m_result, m_store;
  bit [3:0]  m_rd, m_flags;
  bit        m_reg_wr, m_mem_rd, m_mem_wr;
  int        m_ret, m_sq;

  localparam logic [3:0] EQ = 4'd0, NE = 4'd1, CS = 4'd2, CC = 4'd3;
  localparam logic [3:0] MI = 4'd4, PL = 4'd5, VS = 4'd6, VC = 4'd7;
  localparam logic [3:0] HI = 4'd8, LS = 4'd9, GE = 4'd10, LT = 4'd11;
  localparam logic [3:0] GT = 4'd12, LE = 4'd13, AL = 4'd14, NV = 4'd15;

  ex_mem_stage #(.WIDTH(16), .RADDR_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall),
    .flush(flush), .alu_out(alu_out), .alu_n(alu_n), .alu_z(alu_z),
    .alu_v(alu_v), .alu_c(alu_c), .set_flags(set_flags), .cond(cond),
    .reg_wr_in(reg_wr_in), .rd_in(rd_in), .mem_rd_in(mem_rd_in),
    .mem_wr_in(mem_wr_in), .store_data_in(store_data_in),
    .out_valid(out_valid), .result(result), .rd(rd), .reg_wr(reg_wr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .store_data(store_data),
    .flags(flags), .retired_cnt(retired_cnt), .squash_cnt(squash_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit cond_ok(input bit [3:0] f, input bit [3:0] c);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      EQ: return z;
      NE: return !z;
      CS: return cy;
      CC: return !cy;
      MI: return n;
      PL: return !n;
      VS: return v;
      VC: return !v;
      HI: return cy && !z;
      LS: return !cy || z;
      GE: return n == v;
      LT: return n != v;
      GT: return !z && (n == v);
      LE: return z || (n != v);
      AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle_inputs();
    rst = 0; in_valid = 0; stall = 0; flush = 0;
    alu_out = 0; alu_n = 0; alu_z = 0; alu_v = 0; alu_c = 0;
    set_flags = 0; cond = AL; reg_wr_in = 0; rd_in = 0;
    mem_rd_in = 0; mem_wr_in = 0; store_data_in = 0;
  endtask

  task automatic bubble_model();
    m_valid = 0; m_result = 0; m_rd = 0; m_store = 0;
    m_reg_wr = 0; m_mem_rd = 0; m_mem_wr = 0;
  endtask

  // one clock edge; model advances with the same inputs
  task automatic step();
    bit pass;
    pass = cond_ok(m_flags, cond);
    @(posedge clk);
    if (rst) begin
      bubble_model(); m_flags = 0; m_ret = 0; m_sq = 0;
    end else if (flush) begin
      bubble_model();
    end else if (stall) begin
      m_valid = m_valid;
    end else if (in_valid && pass) begin
      m_valid = 1; m_result = alu_out; m_rd = rd_in;
      m_store = store_data_in; m_reg_wr = reg_wr_in;
      m_mem_rd = mem_rd_in; m_mem_wr = mem_wr_in;
      m_ret = (m_ret + 1) % 65536;
      if (set_flags) m_flags = {alu_n, alu_z, alu_c, alu_v};
    end else begin
      bubble_model();
      if (in_valid) m_sq = (m_sq + 1) % 65536;
    end
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; step(); step(); rst = 0;
  endtask

  task automatic instr(input logic [3:0] c, input logic sf,
                       input logic [3:0] nzcv, input logic [15:0] d);
    idle_inputs();
    in_valid = 1; cond = c; set_flags = sf;
    {alu_n, alu_z, alu_c, alu_v} = nzcv; alu_out = d;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; in_valid = 1; set_flags = 1; reg_wr_in = 1;
    mem_wr_in = 1; mem_rd_in = 1; alu_out = 16'hDEAD;
    {alu_n, alu_z, alu_c, alu_v} = 4'hF;
    step(); step();
    n_vec++;
    if ({out_valid, reg_wr, mem_wr, mem_rd, flags} !== 8'h00 ||
        retired_cnt !== 0 || squash_cnt !== 0) begin
      n_err++;
      $display("FAIL reset: got v=%b rw=%b mw=%b mr=%b f=%b ret=%h sq=%h want all zero",
               out_valid, reg_wr, mem_wr, mem_rd, flags, retired_cnt, squash_cnt);
    end
    rst = 0;
  endtask

  task automatic test_cmp_branch();
    do_reset();
    instr(AL, 1, 4'b0100, 16'h0000);
    n_vec++;
    if (flags !== 4'b0100) begin
      n_err++; $display("FAIL cmp_flags: got %b want 0100", flags);
    end
    idle_inputs();
    in_valid = 1; cond = EQ; reg_wr_in = 1; rd_in = 3; alu_out = 16'h1234;
    step();
    n_vec++;
    if ({out_valid, reg_wr} !== 2'b11 || result !== 16'h1234 ||
        rd !== 4'd3 || retired_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL branch_eq: got v=%b rw=%b res=%h rd=%0d ret=%0d want 1 1 1234 3 2",
               out_valid, reg_wr, result, rd, retired_cnt);
    end
  endtask

  task automatic test_squash();
    do_reset();
    idle_inputs();
    in_valid = 1; cond = EQ; set_flags = 1; mem_wr_in = 1; alu_z = 1;
    step();
    n_vec++;
    if (out_valid !== 0 || mem_wr !== 0 || flags !== 4'b0000 ||
        squash_cnt !== 16'd1 || retired_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL squash: got v=%b mw=%b f=%b sq=%0d ret=%0d want 0 0 0000 1 0",
               out_valid, mem_wr, flags, squash_cnt, retired_cnt);
    end
  endtask

  task automatic test_stall_flush();
    logic [15:0] r0, s0;
    do_reset();
    instr(AL, 1, 4'b1010, 16'hAAAA);
    r0 = retired_cnt; s0 = squash_cnt;
    n_vec++;
    if (r0 !== 16'd1 || flags !== 4'b1010) begin
      n_err++; $display("FAIL stall_pre: got ret=%0d f=%b want 1 1010", r0, flags);
    end
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      stall = 1; in_valid = 1; alu_out = 16'h5555; set_flags = 1;
      {alu_n, alu_z, alu_c, alu_v} = 4'b0101;
      step();
      n_vec++;
      if (result !== 16'hAAAA || out_valid !== 1 || flags !== 4'b1010 ||
          retired_cnt !== 16'd1 || squash_cnt !== 16'd0) begin
        n_err++;
        $display("FAIL stall_hold%0d: got res=%h v=%b f=%b ret=%0d sq=%0d want AAAA 1 1010 1 0",
                 i, result, out_valid, flags, retired_cnt, squash_cnt);
      end
    end
    idle_inputs();
    stall = 1; flush = 1; in_valid = 1; set_flags = 1;
    alu_out = 16'h5555; {alu_n, alu_z, alu_c, alu_v} = 4'b0101;
    step();
    n_vec++;
    if (out_valid !== 0 || result !== 0 || flags !== 4'b1010 ||
        retired_cnt !== 16'd1 || squash_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL stall_flush: got v=%b res=%h f=%b ret=%0d sq=%0d want 0 0000 1010 1 0",
               out_valid, result, flags, retired_cnt, squash_cnt);
    end
  endtask

  task automatic test_signed_conds();
    logic [3:0] cl [8];
    bit         ex [8];
    cl = '{GE, LT, GT, LE, HI, LS, NV, AL};
    ex = '{0, 1, 0, 1, 0, 1, 0, 1};
    for (int i = 0; i < 8; i++) begin
      if (i == 0) instr(AL, 1, 4'b1000, 16'h0001);
      if (i == 4) instr(AL, 1, 4'b0110, 16'h0002);
      instr(cl[i], 0, 4'b0000, 16'h0100 + 16'(i));
      n_vec++;
      if (out_valid !== ex[i]) begin
        n_err++;
        $display("FAIL cond_%0d: flags=%b got out_valid=%b want %b",
                 cl[i], flags, out_valid, ex[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(63) == 0);
      in_valid = ($urandom_range(7) != 0);
      stall = ($urandom_range(4) == 0);
      flush = ($urandom_range(7) == 0);
      alu_out = 16'($urandom);
      {alu_n, alu_z, alu_c, alu_v} = 4'($urandom);
      set_flags = ($urandom_range(2) == 0);
      cond = 4'($urandom);
      reg_wr_in = 1'($urandom); rd_in = 4'($urandom);
      mem_rd_in = 1'($urandom); mem_wr_in = 1'($urandom);
      store_data_in = 16'($urandom);
      step();
      n_vec++;
      if ({out_valid, result, rd, reg_wr, mem_rd, mem_wr, store_data, flags,
           retired_cnt, squash_cnt} !==
          {m_valid, m_result, m_rd, m_reg_wr, m_mem_rd, m_mem_wr, m_store,
           m_flags, 16'(m_ret), 16'(m_sq)}) begin
        n_err++;
        $display("FAIL random%0d: got v=%b r=%h rd=%h c=%b%b%b sd=%h f=%b ret=%h sq=%h want v=%b r=%h rd=%h c=%b%b%b sd=%h f=%b ret=%h sq=%h",
                 i, out_valid, result, rd, reg_wr, mem_rd, mem_wr, store_data,
                 flags, retired_cnt, squash_cnt, m_valid, m_result, m_rd,
                 m_reg_wr, m_mem_rd, m_mem_wr, m_store, m_flags,
                 16'(m_ret), 16'(m_sq));
      end
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 65535; i++)
      instr(AL, 0, 4'b0000, 16'($urandom));
    n_vec++;
    if (retired_cnt !== 16'hFFFF || squash_cnt !== 0) begin
      n_err++;
      $display("FAIL wrap_ffff: got ret=%h sq=%h want ffff 0000", retired_cnt, squash_cnt);
    end
    instr(AL, 1, 4'b1001, 16'h7777);
    n_vec++;
    if (retired_cnt !== 16'h0000 || flags !== 4'b1001 || squash_cnt !== 0) begin
      n_err++;
      $display("FAIL wrap_0000: got ret=%h f=%b sq=%h want 0000 1001 0000",
               retired_cnt, flags, squash_cnt);
    end
    instr(AL, 0, 4'b0000, 16'h8888);
    n_vec++;
    if (retired_cnt !== 16'h0001 || squash_cnt !== 0 || result !== 16'h8888) begin
      n_err++;
      $display("FAIL wrap_0001: got ret=%h sq=%h res=%h want 0001 0000 8888",
               retired_cnt, squash_cnt, result);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_cmp_branch();
    test_squash();
    test_stall_flush();
    test_signed_conds();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
